mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the core's single external memory port between the instruction-fetch and data-fetch requesters. It sequences one transaction at a time and returns read data with a one-cycle ready pulse. It also generates the `stall_for_instr_fetch` and `stall_for_data_fetch` signals consumed by the pipeline controller. Data fetch has priority, bounded by an anti-starvation limit so instruction fetch always progresses.

## Interface
Parameters:
- `XLEN`, 32: address/data width.
- `MAX_D_STREAK`, 4: max consecutive D grants while I is pending; must be ≥1.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; one clock, asynchronous, active-low.
- `i_req_i` in 1: instruction read request, held until `i_ready_o`.
- `i_addr_i` in XLEN: instruction address.
- `i_data_o` out XLEN: instruction read data, valid with `i_ready_o`.
- `i_ready_o` out 1: one-cycle completion pulse for I.
- `d_req_i` in 1: data request, held until `d_ready_o`.
- `d_we_i` in 1: 1 = write.
- `d_addr_i` in XLEN: data address.
- `d_wdata_i` in XLEN: write data.
- `d_be_i` in XLEN/8: byte enables.
- `d_rdata_o` out XLEN: read data, valid with `d_ready_o`.
- `d_ready_o` out 1: one-cycle completion pulse for D.
- `m_req_o` out 1: memory request, held until `m_ready_i`.
- `m_we_o` out 1: memory write enable.
- `m_addr_o` out XLEN: memory address.
- `m_wdata_o` out XLEN: memory write data.
- `m_be_o` out XLEN/8: memory byte enables (all ones for I).
- `m_rdata_i` in XLEN: memory read data, sampled with `m_ready_i`.
- `m_ready_i` in 1: memory completion; ignored unless `m_req_o`=1.
- `stall_for_instr_fetch_o` out 1: `i_req_i & ~i_ready_o`.
- `stall_for_data_fetch_o` out 1: `d_req_i & ~d_ready_o`.

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE → BUSY_D: `d_req_i` & (`~i_req_i` | streak < MAX_D_STREAK).
- IDLE → BUSY_I: `i_req_i` and D not granted.
- IDLE stays IDLE when there is no request.
- On grant, register the winner's addr/wdata/be/we into `m_*`. For I: `m_we_o`=0, `m_be_o`=all ones.
- BUSY_x: `m_req_o`=1 and `m_*` stay stable. On `m_ready_i`, register `m_rdata_i` into `x_data_o`/`x_rdata_o`, set `x_ready_o`=1, go to DONE.
- DONE: ready pulse high this cycle only; `m_req_o`=0; requests ignored; → IDLE.
- Streak counter, width clog2(MAX_D_STREAK+1):
  - D grant with `i_req_i`=1: increment, saturating.
  - D grant with `i_req_i`=0: clear.
  - I grant: clear.
- Read data registers hold their value until the next completion for the same requester. Writes also pulse `d_ready_o`; `d_rdata_o` is then undefined.
- Stall outputs are combinational and may be high during reset if requests are high.
- Reset (any state, asynchronous): state IDLE; `m_req_o`, `m_we_o`, `i_ready_o`, `d_ready_o` = 0; `m_addr_o`, `m_wdata_o`, `m_be_o`, `i_data_o`, `d_rdata_o` = 0; streak = 0. A late `m_ready_i` after reset is ignored.

## Timing
- Request seen in IDLE at cycle 0 → `m_req_o`=1 at cycle 1.
- `m_ready_i` at cycle k≥1 → `x_ready_o` and data at k+1 → IDLE at k+2.
- Minimum occupancy is 3 cycles per transaction, so back-to-back grants are at least 3 cycles apart.
- A requester must deassert or change its request by the cycle after its ready pulse. IDLE samples it then.
- Simultaneous I and D in IDLE: D wins unless streak = MAX_D_STREAK.
- A request raised during BUSY/DONE waits for IDLE; it is never dropped.

## Test plan
- Single I read, addr 0x100, memory answers 2 cycles after `m_req_o` → `m_addr_o`=0x100, `m_be_o`=0xF, `i_ready_o` pulses once with data 0xDEADBEEF; `stall_for_instr_fetch_o` falls the same cycle.
- Simultaneous I (0x200) and D read (0x8000) → D served first, then I; the two `m_req_o` periods are separated by DONE and IDLE.
- D write 0x8004, data 0x12345678, be 0x3 → `m_we_o`=1, `m_wdata_o`/`m_be_o` match; `d_ready_o` pulses; no I ready.
- D continuously requesting with I pending, MAX_D_STREAK=4 → exactly 4 D grants, then 1 I grant, then the streak restarts.
- `rst_ni` low mid-BUSY_D → outputs zero immediately; after release, a held `m_ready_i` is ignored; a new D request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// and data fetch. One transaction is in flight at a time. Data fetch has
// priority, but a bounded streak counter guarantees instruction fetch progress.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // instruction requester
    input  logic              i_req_i,
    input  logic [XLEN-1:0]   i_addr_i,
    output logic [XLEN-1:0]   i_data_o,
    output logic              i_ready_o,
    // data requester
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [XLEN-1:0]   d_addr_i,
    input  logic [XLEN-1:0]   d_wdata_i,
    input  logic [XLEN/8-1:0] d_be_i,
    output logic [XLEN-1:0]   d_rdata_o,
    output logic              d_ready_o,
    // memory port
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [XLEN-1:0]   m_addr_o,
    output logic [XLEN-1:0]   m_wdata_o,
    output logic [XLEN/8-1:0] m_be_o,
    input  logic [XLEN-1:0]   m_rdata_i,
    input  logic              m_ready_i,
    // pipeline stalls
    output logic              stall_for_instr_fetch_o,
    output logic              stall_for_data_fetch_o
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [STREAK_W-1:0] streak;
    logic                grant_d;
    logic                grant_i;
    logic                i_done;
    logic                d_done;

    // Grant decision in IDLE: D wins unless I has already waited out a full D streak.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = d_req_i && (!i_req_i || (streak < STREAK_MAX));
            grant_i = i_req_i && !grant_d;
        end
    end

    // The port is busy exactly while a transaction is outstanding; m_ready_i only counts then.
    assign m_req_o = (state == BUSY_I) || (state == BUSY_D);
    assign i_done  = (state == BUSY_I) && m_ready_i;
    assign d_done  = (state == BUSY_D) && m_ready_i;

    // Next-state logic for the one-transaction-at-a-time sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = BUSY_D;
                end else if (grant_i) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready_i) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winner's request into the memory port; held stable while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_we_o    <= 1'b0;
            m_addr_o  <= '0;
            m_wdata_o <= '0;
            m_be_o    <= '0;
        end else if (grant_d) begin
            m_we_o    <= d_we_i;
            m_addr_o  <= d_addr_i;
            m_wdata_o <= d_wdata_i;
            m_be_o    <= d_be_i;
        end else if (grant_i) begin
            m_we_o    <= 1'b0;
            m_addr_o  <= i_addr_i;
            m_be_o    <= '1;
        end
    end

    // Completion: one-cycle ready pulse; read data held until the same requester completes again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_ready_o <= 1'b0;
            d_ready_o <= 1'b0;
            i_data_o  <= '0;
            d_rdata_o <= '0;
        end else begin
            i_ready_o <= i_done;
            d_ready_o <= d_done;
            if (i_done) begin
                i_data_o <= m_rdata_i;
            end
            if (d_done) begin
                d_rdata_o <= m_rdata_i;
            end
        end
    end

    // Anti-starvation streak: counts D grants taken while I was waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!i_req_i) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end else if (grant_i) begin
            streak <= '0;
        end
    end

    assign stall_for_instr_fetch_o = i_req_i && !i_ready_o;
    assign stall_for_data_fetch_o  = d_req_i && !d_ready_o;

endmodule
